mem_cmd_master: RTL and testbench
=================================

MEM_CMD_MASTER -- requirements
Module: mem_cmd_master

Interface
REQ-001 Parameter READ_LAT, default 2, means cycles (1..15) from end of HOLD until mem_data_in is sampled on reads.
REQ-002 Parameter FIFO_DEPTH, default 4, means the request queue depth (power of two, >=2).
REQ-003 clk  input  1  is the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 req_valid  input  1  means a request is offered.
REQ-006 req_ready  output  1  means the queue accepts the request.
REQ-007 req_write  input  1  selects the operation: 1 = write, 0 = read.
REQ-008 req_addr  input  8  is the request address.
REQ-009 req_wdata  input  8  is the write data (ignored on reads).
REQ-010 rsp_valid  output  1  means read data is available.
REQ-011 rsp_ready  input  1  means the consumer takes the response.
REQ-012 rsp_rdata  output  8  is the read data.
REQ-013 mem_start  output  1  is the memory strobe; memory samples on its rising edge.
REQ-014 mem_write  output  1  is the memory write enable.
REQ-015 mem_addr  output  8  is the memory address.
REQ-016 mem_data_out / mem_data_oe / mem_data_in  output 8 / output 1 / input 8  form the split data bus; the top level builds the tri-state.

Function
REQ-017 The queue SHALL be a FIFO_DEPTH-entry FIFO of {write, addr, wdata}; push on req_valid&&req_ready; req_ready = !full.
REQ-018 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD, WAIT, RESP.
REQ-019 In IDLE with the FIFO non-empty, it SHALL pop one entry into the command registers and go to SETUP.
REQ-020 In IDLE with the FIFO empty, it SHALL stay in IDLE.
REQ-021 SETUP, STROBE and HOLD SHALL each last exactly 1 cycle; mem_start = 1 only in STROBE, so each command yields exactly one rising edge.
REQ-022 mem_addr and mem_write SHALL be stable from SETUP through HOLD and SHALL retain their last value elsewhere.
REQ-023 For writes, mem_data_oe = 1 and mem_data_out = wdata during SETUP, STROBE and HOLD; mem_data_oe = 0 in every other state.
REQ-024 For reads, mem_data_oe SHALL stay 0 throughout.
REQ-025 After HOLD, a write SHALL go to IDLE, giving 4 cycles per write and no response.
REQ-026 After HOLD, a read SHALL go to WAIT for exactly READ_LAT cycles, using a 4-bit down-counter.
REQ-027 mem_data_in SHALL be captured into rsp_rdata on the last WAIT cycle; the next state is RESP.
REQ-028 In RESP, rsp_valid = 1 and rsp_rdata is held stable until rsp_ready.
REQ-029 On rsp_valid&&rsp_ready the FSM SHALL go to IDLE, so the next command starts SETUP no earlier than 2 cycles later.
REQ-030 Pushes SHALL continue in every state; pops occur only in IDLE.
REQ-031 Push and pop in the same cycle SHALL keep the FIFO count unchanged.
REQ-032 When the FIFO is full, req_ready = 0 and an offered request is neither lost nor duplicated.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH; commands issue in strict arrival order.
REQ-034 Read latency from the pop cycle N SHALL be: SETUP N+1, STROBE N+2, HOLD N+3, WAIT N+4..N+3+READ_LAT, rsp_valid from N+4+READ_LAT.

Reset
REQ-035 While rst_n = 0 at posedge clk, outputs SHALL be: state IDLE, FIFO empty, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, mem_start = 0, mem_write = 0, mem_addr = 0, mem_data_out = 0, mem_data_oe = 0.
REQ-036 Reset in any state, including STROBE or RESP, SHALL abort the command, discard queued entries and the pending response, and drop mem_start at the same edge.

Verification
REQ-037 Write 0x42/0x5A popped at N -> mem_addr = 0x42, mem_data_out = 0x5A, oe = 1, mem_write = 1 for N+1..N+3; mem_start = 1 only at N+2; no rsp_valid.
REQ-038 Read 0x42 with mem_data_in = 0x5A, READ_LAT = 2, rsp_ready = 1 -> oe stays 0; rsp_valid = 1 at N+6 only; rsp_rdata = 0x5A.
REQ-039 Read then 5 writes while rsp_ready = 0 -> FIFO fills at 4 and req_ready = 0; the 5th request is held; after rsp_ready all 5 writes issue in order with 5 mem_start pulses total.
REQ-040 Hold rsp_ready = 0 for 10 cycles with mem_data_in changing -> rsp_valid and rsp_rdata stay constant; mem_start stays 0.
REQ-041 Drive rst_n = 0 during STROBE of a write, with 2 entries queued -> next cycle mem_start = 0, oe = 0, req_ready = 1; after release no mem_start occurs without a new request.
REQ-042 Push 9 mixed commands with random stalls -> the mem_addr sequence matches push order across pointer wrap; every read gets exactly one response.

Source files
------------

// File: rtl/mem_cmd_master.sv
// Queued command master: buffers {write, addr, wdata} requests and replays them as SETUP/STROBE/HOLD memory cycles.
// Latency: pop->SETUP 1 cycle; 4 cycles per write; a read's rsp_valid rises 4+READ_LAT cycles after its pop.
// Backpressure: req_ready drops while the queue is full; a pending read response stalls the FSM until rsp_ready.
module mem_cmd_master #(
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       mem_start,
    output logic       mem_write,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_out,
    output logic       mem_data_oe,
    input  logic [7:0] mem_data_in
);

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAIT, S_RESP
    } state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    cmd_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        nxt;
    cmd_t          cmd_q;
    logic [3:0]    wait_cnt;
    logic          load_wait;
    logic          capture;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = req_valid && !full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (!empty) nxt = S_SETUP;
            S_SETUP:  nxt = S_STROBE;
            S_STROBE: nxt = S_HOLD;
            S_HOLD:   nxt = cmd_q.write ? S_IDLE : S_WAIT;
            S_WAIT:   if (wait_cnt == 4'd0) nxt = S_RESP;
            S_RESP:   if (rsp_ready) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = !full;
        pop         = (state == S_IDLE) && !empty;
        mem_start   = (state == S_STROBE);
        rsp_valid   = (state == S_RESP);
        mem_data_oe = cmd_q.write && (state inside {S_SETUP, S_STROBE, S_HOLD});
        load_wait   = (state == S_HOLD) && !cmd_q.write;
        capture     = (state == S_WAIT) && (wait_cnt == 4'd0);
    end

    // Queue storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_q     <= '0;
            wait_cnt  <= 4'd0;
            rsp_rdata <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                cmd_q  <= fifo_mem[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (load_wait) begin
                wait_cnt <= LAT_M1;
            end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (capture) rsp_rdata <= mem_data_in;
        end
    end

    // Command registers hold their last value outside SETUP..HOLD.
    assign mem_write    = cmd_q.write;
    assign mem_addr     = cmd_q.addr;
    assign mem_data_out = cmd_q.wdata;

endmodule

// File: tb/tb_mem_cmd_master.sv
// Bench for mem_cmd_master: cycle-exact vector table plus scoreboarded multi-cycle sequences.
module tb_mem_cmd_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       mem_start;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_out;
    logic       mem_data_oe;
    logic [7:0] mem_data_in;

    logic       mem_mode;
    logic [7:0] junk;

    always #5 clk = ~clk;

    // Memory model: read data is the address xor 0x18, or free-running junk.
    assign mem_data_in = mem_mode ? (mem_addr ^ 8'h18) : junk;

    mem_cmd_master #(.READ_LAT(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_start(mem_start), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_data_oe(mem_data_oe), .mem_data_in(mem_data_in)
    );

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct {
        logic       rst_n, vld, wr;
        logic [7:0] addr, wdata;
        logic       rrdy;
        logic       e_rdy, e_start, e_mwr;
        logic [7:0] e_addr;
        logic       e_oe;
        logic [7:0] e_dout;
        logic       e_rvld;
        logic [7:0] e_rdata;
    } vec_t;

    vec_t       vt [14];
    cmd_t       exp_cmd [$];
    logic [7:0] exp_rsp [$];
    int         checks = 0;
    int         failures = 0;
    int         pulses = 0;
    int         rsp_taken = 0;
    logic       prev_start = 1'b0;
    bit         rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are set at the falling edge; the rising edge is applied; outputs are checked at the next falling edge.
    task automatic step();
        cmd_t n;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        if (!rst_n) begin
            exp_cmd.delete();
            exp_rsp.delete();
        end else begin
            if (req_valid && req_ready) begin
                n.wr = req_write; n.addr = req_addr; n.wdata = req_wdata;
                exp_cmd.push_back(n);
                if (!req_write) exp_rsp.push_back(req_addr ^ 8'h18);
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_rsp[0]);
                    if (rsp_ready) begin
                        void'(exp_rsp.pop_front());
                        rsp_taken++;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (mem_start) begin
            chk("start_width", prev_start, 1'b0);
            if (!prev_start) begin
                pulses++;
                if (exp_cmd.size() == 0) begin
                    chk("start_unexpected", mem_start, 1'b0);
                end else begin
                    n = exp_cmd.pop_front();
                    chk("cmd_addr", mem_addr, n.addr);
                    chk("cmd_write", mem_write, n.wr);
                    chk("cmd_oe", mem_data_oe, n.wr);
                    if (n.wr) chk("cmd_wdata", mem_data_out, n.wdata);
                end
            end
        end
        prev_start = mem_start;
    endtask

    task automatic offer(input logic wr, input logic [7:0] a, input logic [7:0] d);
        bit acc = 1'b0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        for (int k = 0; k < 200 && !acc; k++) begin
            acc = req_ready;
            step();
        end
        chk("offer_accepted", acc, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 300 && (exp_cmd.size() != 0 || exp_rsp.size() != 0); k++) step();
        repeat (5) step();
        chk("drain_cmd", exp_cmd.size(), 0);
        chk("drain_rsp", exp_rsp.size(), 0);
        chk("drain_idle_rsp", rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int r0;
        int nreads;
        logic wr;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        rsp_ready = 1'b1; mem_mode = 1'b1; junk = 8'h00;
        @(negedge clk);

        //          rst  vld  wr   addr   wdata  rrdy | rdy  start mwr  maddr  oe   dout   rvld rdata
        vt[0]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,8'h00};
        vt[1]  = '{1'b1,1'b1,1'b1,8'h42,8'h5A,1'b1, 1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,8'h00};
        vt[2]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b1,8'h42,1'b1,8'h5A,1'b0,8'h00};
        vt[3]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b1,1'b1,8'h42,1'b1,8'h5A,1'b0,8'h00};
        vt[4]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b1,8'h42,1'b1,8'h5A,1'b0,8'h00};
        vt[5]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b1,8'h42,1'b0,8'h00,1'b0,8'h00};
        vt[6]  = '{1'b1,1'b1,1'b0,8'h42,8'h00,1'b1, 1'b1,1'b0,1'b1,8'h42,1'b0,8'h00,1'b0,8'h00};
        vt[7]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h42,1'b0,8'h00,1'b0,8'h00};
        vt[8]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b1,1'b0,8'h42,1'b0,8'h00,1'b0,8'h00};
        vt[9]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h42,1'b0,8'h00,1'b0,8'h00};
        vt[10] = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h42,1'b0,8'h00,1'b0,8'h00};
        vt[11] = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h42,1'b0,8'h00,1'b0,8'h00};
        vt[12] = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h42,1'b0,8'h00,1'b1,8'h5A};
        vt[13] = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b0,8'h42,1'b0,8'h00,1'b0,8'h5A};

        for (int i = 0; i < 14; i++) begin
            rst_n = vt[i].rst_n; req_valid = vt[i].vld; req_write = vt[i].wr;
            req_addr = vt[i].addr; req_wdata = vt[i].wdata; rsp_ready = vt[i].rrdy;
            step();
            chk($sformatf("v%0d_req_ready", i), req_ready, vt[i].e_rdy);
            chk($sformatf("v%0d_mem_start", i), mem_start, vt[i].e_start);
            chk($sformatf("v%0d_mem_write", i), mem_write, vt[i].e_mwr);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_mem_data_oe", i), mem_data_oe, vt[i].e_oe);
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vt[i].e_rvld);
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vt[i].e_rdata);
            if (vt[i].e_oe || !vt[i].rst_n) chk($sformatf("v%0d_mem_data_out", i), mem_data_out, vt[i].e_dout);
        end
        req_valid = 1'b0;

        // Read stalls in RESP while four writes fill the queue and a fifth waits.
        p0 = pulses;
        rsp_ready = 1'b0;
        offer(1'b0, 8'h10, 8'h00);
        for (int i = 0; i < 4; i++) offer(1'b1, 8'(8'h60 + i), 8'(8'hA0 + i));
        chk("fifo_full_req_ready", req_ready, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h64; req_wdata = 8'hA4;
        for (int k = 0; k < 50 && !rsp_valid; k++) step();
        chk("rsp_arrive", rsp_valid, 1'b1);
        mem_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            junk = 8'($urandom);
            step();
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_rdata", rsp_rdata, 8'h08);
            chk("hold_mem_start", mem_start, 1'b0);
            chk("hold_req_ready", req_ready, 1'b0);
        end
        mem_mode  = 1'b1;
        rsp_ready = 1'b1;
        offer(1'b1, 8'h64, 8'hA4);
        drain();
        chk("seq_a_pulses", pulses - p0, 6);

        // Reset lands in STROBE of a write with two more writes queued.
        offer(1'b1, 8'h21, 8'h11);
        offer(1'b1, 8'h22, 8'h12);
        offer(1'b1, 8'h23, 8'h13);
        chk("pre_rst_strobe", mem_start, 1'b1);
        rst_n = 1'b0;
        step();
        chk("rst_mem_start", mem_start, 1'b0);
        chk("rst_mem_data_oe", mem_data_oe, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (20) step();
        chk("no_start_after_rst", pulses - p0, 0);

        // Nine mixed commands with random gaps and random rsp_ready, wrapping the pointers.
        p0 = pulses; r0 = rsp_taken; nreads = 0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 3)) step();
            wr = (i % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!wr) nreads++;
            offer(wr, 8'(8'h80 + i * 37), 8'($urandom));
        end
        drain();
        chk("mixed_pulses", pulses - p0, 9);
        chk("mixed_rsp_count", rsp_taken - r0, nreads);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
